ysyx_22040759_div: RTL and testbench
====================================

Name: ysyx_22040759_div

Overview:
- Multi-cycle RV32M divide unit for DIV/DIVU/REM/REMU.
- Sits between the GPR read ports and the GPR write port:
  - consumes rdata1/rdata2 (dividend/divisor) plus destination rd;
  - produces wdata/waddr/wen-qualified result for writeback.
- Radix-2 restoring iteration, one quotient bit per cycle, valid/ready handshake on both sides, flush for pipeline kill.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  abort any in-flight operation.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept (high only in IDLE).
- in_signed  input  1  1 = DIV/REM, 0 = DIVU/REMU.
- in_rem  input  1  1 = return remainder, 0 = quotient.
- in_dividend  input  XLEN  rs1 value.
- in_divisor  input  XLEN  rs2 value.
- in_rd  input  5  destination register tag.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts.
- out_result  output  XLEN  quotient or remainder.
- out_rd  output  5  destination tag of result.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - rst is asynchronous active-high; on assertion, immediately: state=IDLE, out_valid=0, out_result=0, out_rd=0, counter=0, internal regs=0.
  - in_ready=1 in the cycle after rst deasserts.
- States: IDLE, CALC, DONE.
- Accept: in_valid & in_ready at a rising edge (edge 0). Latch operands, signed, rem, rd.
  - Signed ops: store |dividend|, |divisor| and result signs: q_neg = sign(a) XOR sign(b); r_neg = sign(a).
- Special cases (decided at accept, go straight to DONE, out_valid high in cycle 1):
  - divisor==0: quotient=32'hFFFF_FFFF, remainder=dividend (both signed and unsigned).
  - Signed overflow, dividend=32'h8000_0000 and divisor=32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0.
- Normal path, CALC:
  - 32 iterations, counter 31 down to 0.
  - Each cycle: partial remainder = {rem[30:0], dividend bit}; if ≥ divisor, subtract and set quotient bit; 33-bit subtraction, no overflow loss.
  - After the last iteration: apply sign correction (two's-complement negate if q_neg/r_neg), select by rem flag, register into out_result → DONE.
  - out_valid first high in cycle 33 after the accept edge. Total latency 33 cycles; throughput 1 op per ≥34 cycles.
- DONE:
  - out_valid=1; out_result/out_rd stable until out_ready sampled high.
  - On handshake → IDLE; in_ready high next cycle. No back-to-back accept in the same cycle as the output handshake.
- flush:
  - Sampled at a rising edge in any state: next state IDLE, out_valid=0 next cycle, result discarded.
  - flush takes priority over in_valid and out_ready in the same cycle; a request presented with flush is not accepted.
- Mid-operation reset: same as power-on reset; no result emitted.
- out_valid never drops without handshake, flush or rst. in_ready is 0 in CALC and DONE.
- Remainder sign follows the dividend, per RISC-V spec.

Decomposition:
- Shared package/define file holds:
  - XLEN;
  - state encodings DIV_IDLE=2'd0, DIV_CALC=2'd1, DIV_DONE=2'd2;
  - constants DIV_ZERO_Q (all ones) and INT_MIN (32'h8000_0000).
- One natural sub-module: ysyx_22040759_div_iter, the combinational single-step restoring subtract/shift (33-bit compare-subtract), instantiated once inside the FSM datapath.

Test Plan:
- DIVU 100/7, rem=0 and rem=1 → out_result=14 and 2, out_valid exactly 33 cycles after accept, out_rd echoes in_rd=5'd12.
- DIV -7/2 → quotient 32'hFFFF_FFFD (-3); REM -7/2 → 32'hFFFF_FFFF (-1); REM 7/-2 → 1.
- Divide by zero: DIVU 123/0 → 32'hFFFF_FFFF; REMU 123/0 → 123; both with out_valid in cycle 1.
- Overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF → 32'h8000_0000; REM → 0; 1-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and out_result stable, in_ready=0; raise out_ready → in_ready=1 next cycle.
- flush at cycle 15 of CALC, and async rst pulse mid-CALC → no out_valid; following DIVU 50/5 returns 10 correctly.

Source files
------------

// File: rtl/ysyx_22040759_div_pkg.sv
// Shared constants and types for the ysyx_22040759 RV32M divide unit.
// Holds operand width, FSM encodings, special-case results and a negate helper.
package ysyx_22040759_div_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

  typedef struct packed {
    logic            sgn;
    logic            rem;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
  } div_req_t;

  // Two's-complement negate when requested; used for both operand magnitude and result sign fix-up.
  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] val);
    logic [XLEN-1:0] res;
    if (neg) begin
      res = ~val + 32'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22040759_div_iter.sv
// One restoring-division step: shift in a dividend bit, compare-subtract the divisor
// with a 33-bit difference so unsigned divisors above 2^31 are handled exactly.
module ysyx_22040759_div_iter
  import ysyx_22040759_div_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] partial_s;
  logic [XLEN:0] diff_s;

  // rem_in < divisor always holds, so the difference MSB is a clean borrow flag.
  always_comb begin
    partial_s = {rem_in, bit_in};
    diff_s    = partial_s - {1'b0, divisor};
    q_bit     = ~diff_s[XLEN];
    if (q_bit) begin
      rem_out = diff_s[XLEN-1:0];
    end else begin
      rem_out = partial_s[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ysyx_22040759_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready
// handshakes on request and writeback sides and a pipeline-kill flush.
module ysyx_22040759_div
  import ysyx_22040759_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_signed,
  input  logic            in_rem,
  input  logic [XLEN-1:0] in_dividend,
  input  logic [XLEN-1:0] in_divisor,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  dvd_r;
  logic [XLEN-1:0]  dvs_r;
  logic [XLEN-1:0]  rem_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             rem_sel_r;
  logic             out_valid_r;
  logic [XLEN-1:0]  out_result_r;
  logic [4:0]       out_rd_r;

  div_req_t         req_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [XLEN-1:0]  a_abs_s;
  logic [XLEN-1:0]  b_abs_s;
  logic             div_zero_s;
  logic             ovf_s;
  logic [XLEN-1:0]  special_res_s;

  logic [XLEN-1:0]  iter_rem_s;
  logic             iter_q_s;
  logic [XLEN-1:0]  quot_next_s;
  logic [XLEN-1:0]  final_res_s;

  // Accept-time decode: operand magnitudes, result signs and the two early-exit cases.
  always_comb begin
    req_s.sgn      = in_signed;
    req_s.rem      = in_rem;
    req_s.dividend = in_dividend;
    req_s.divisor  = in_divisor;
    a_neg_s    = req_s.sgn & req_s.dividend[XLEN-1];
    b_neg_s    = req_s.sgn & req_s.divisor[XLEN-1];
    a_abs_s    = neg_if(a_neg_s, req_s.dividend);
    b_abs_s    = neg_if(b_neg_s, req_s.divisor);
    div_zero_s = (req_s.divisor == 32'h0000_0000);
    ovf_s      = req_s.sgn & (req_s.dividend == INT_MIN) & (req_s.divisor == 32'hFFFF_FFFF);
    if (div_zero_s) begin
      special_res_s = req_s.rem ? req_s.dividend : DIV_ZERO_Q;
    end else if (ovf_s) begin
      special_res_s = req_s.rem ? 32'h0000_0000 : INT_MIN;
    end else begin
      special_res_s = 32'h0000_0000;
    end
  end

  ysyx_22040759_div_iter u_iter (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[XLEN-1]),
    .divisor (dvs_r),
    .rem_out (iter_rem_s),
    .q_bit   (iter_q_s)
  );

  // Quotient bits shift into the vacated low end of the dividend register.
  always_comb begin
    quot_next_s = {dvd_r[XLEN-2:0], iter_q_s};
    if (rem_sel_r) begin
      final_res_s = neg_if(r_neg_r, iter_rem_s);
    end else begin
      final_res_s = neg_if(q_neg_r, quot_next_s);
    end
  end

  // Control FSM and datapath registers; flush outranks both handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= DIV_IDLE;
      cnt_r        <= '0;
      dvd_r        <= '0;
      dvs_r        <= '0;
      rem_r        <= '0;
      q_neg_r      <= 1'b0;
      r_neg_r      <= 1'b0;
      rem_sel_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      out_result_r <= '0;
      out_rd_r     <= 5'd0;
    end else if (flush) begin
      state_r     <= DIV_IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (in_valid) begin
            dvd_r     <= a_abs_s;
            dvs_r     <= b_abs_s;
            rem_r     <= '0;
            q_neg_r   <= a_neg_s ^ b_neg_s;
            r_neg_r   <= a_neg_s;
            rem_sel_r <= in_rem;
            out_rd_r  <= in_rd;
            if (div_zero_s || ovf_s) begin
              out_result_r <= special_res_s;
              out_valid_r  <= 1'b1;
              state_r      <= DIV_DONE;
            end else begin
              cnt_r   <= 5'd31;
              state_r <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_r <= iter_rem_s;
          dvd_r <= quot_next_s;
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == 5'd0) begin
            out_result_r <= final_res_s;
            out_valid_r  <= 1'b1;
            state_r      <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= DIV_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= DIV_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (state_r == DIV_IDLE);
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_rd     = out_rd_r;

endmodule

// File: tb/tb_ysyx_22040759_div.sv
// Self-checking bench for ysyx_22040759_div: directed vector table, random ops
// against an arithmetic reference model, and backpressure/flush/reset sequences.
module tb_ysyx_22040759_div;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic        in_rem;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        sgn;
    logic        rem;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  ysyx_22040759_div dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_signed   (in_signed),
    .in_rem      (in_rem),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RISC-V division rules in plain arithmetic.
  task automatic ref_div(input logic sgn, input logic rem, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res, output int lat);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      res = rem ? a : 32'hFFFF_FFFF;
      lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = rem ? 32'd0 : 32'h8000_0000;
      lat = 1;
    end else if (sgn) begin
      res = rem ? 32'(sa % sb) : 32'(sa / sb);
      lat = 33;
    end else begin
      res = rem ? a % b : a / b;
      lat = 33;
    end
  endtask

  task automatic start_op(input logic sgn, input logic rem, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid    = 1'b1;
    in_signed   = sgn;
    in_rem      = rem;
    in_dividend = a;
    in_divisor  = b;
    in_rd       = rd;
    out_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_op(input string name, input logic sgn, input logic rem, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int exp_lat);
    int lat;
    start_op(sgn, rem, a, b, rd);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, out_result, exp_res);
    check({name, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
    check({name, "_ready_after_hs"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    logic [31:0] rres;
    int          rlat;
    logic        rs, rr;
    logic [31:0] ra, rb;
    int          kind;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_rem = 1'b0;
    in_dividend = 32'd0; in_divisor = 32'd0; in_rd = 5'd0; out_ready = 1'b0;

    vecs[0]  = '{1'b0, 1'b0, 32'd100, 32'd7, 5'd12, 32'd14, 33};
    vecs[1]  = '{1'b0, 1'b1, 32'd100, 32'd7, 5'd12, 32'd2, 33};
    vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 33};
    vecs[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'd1, 33};
    vecs[5]  = '{1'b0, 1'b0, 32'd123, 32'd0, 5'd6, 32'hFFFF_FFFF, 1};
    vecs[6]  = '{1'b0, 1'b1, 32'd123, 32'd0, 5'd7, 32'd123, 1};
    vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1};
    vecs[8]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1};
    vecs[9]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd10, 32'hFFFF_FFFF, 33};
    vecs[10] = '{1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 33};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13, 32'h7FFF_FFFE, 33};
    vecs[12] = '{1'b1, 1'b0, 32'd0, 32'd0, 5'd14, 32'hFFFF_FFFF, 1};
    vecs[13] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 32'd0, 5'd31, 32'hFFFF_FFF8, 1};

    repeat (3) @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_out_rd", {27'd0, out_rd}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b,
            vecs[i].rd, vecs[i].exp_res, vecs[i].exp_lat);
    end

    for (int i = 0; i < 40; i++) begin
      rs   = 1'($urandom_range(0, 1));
      rr   = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      kind = $urandom_range(0, 9);
      if (kind == 0) rb = 32'd0;
      else if (kind == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (kind <= 4) begin
        rb = 32'($urandom_range(1, 15));
        if (rs && $urandom_range(0, 1) == 1) rb = -rb;
      end
      ref_div(rs, rr, ra, rb, rres, rlat);
      do_op($sformatf("rand%0d", i), rs, rr, ra, rb, 5'($urandom_range(0, 31)), rres, rlat);
    end

    // Backpressure: output must hold while out_ready stays low.
    start_op(1'b0, 1'b0, 32'd100, 32'd7, 5'd12);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_result", out_result, 32'd14);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Flush during CALC, with a competing request on the same edge.
    start_op(1'b0, 1'b0, 32'd1000, 32'd3, 5'd2);
    repeat (14) @(negedge clk);
    check("calc_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    in_valid = 1'b1; in_signed = 1'b0; in_rem = 1'b0;
    in_dividend = 32'd9; in_divisor = 32'd3; in_rd = 5'd1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    watch_no_valid("flush_no_result", 40);
    do_op("after_flush", 1'b0, 1'b0, 32'd50, 32'd5, 5'd20, 32'd10, 33);

    // Asynchronous reset pulse mid-CALC.
    start_op(1'b1, 1'b0, 32'd77, 32'd7, 5'd21);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_result", out_result, 32'd0);
    check("arst_out_rd", {27'd0, out_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_valid("arst_no_result", 40);
    do_op("after_rst", 1'b0, 1'b0, 32'd50, 32'd5, 5'd22, 32'd10, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
